memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
//  Target side of the core's RAM bus: answers ram_read/ram_write/ram_address
//  with a unified instruction+data word store. After reset it holds the core in
//  reset and accepts a program image over a byte-serial valid/ready loader.
//  It then releases the core and serves fetches, loads and stores. One address
//  is a memory-mapped output register for the bench and board.
// PARAMETERS
//  DEPTH      1024       words of storage; valid addresses 0..DEPTH-1
//  IO_ADDR    24'hFFFFFF store-only output register address
// PORTS
//  clk           in   1   clock; all state on posedge
//  nreset        in   1   reset, asynchronous, active-low
//  ram_read      in   1   core read strobe (fetch or LDR)
//  ram_write     in   1   core write strobe (STR)
//  ram_address   in   24  word address from core
//  ram_wdata     in   32  store data from register file
//  ram_rdata     out  32  read data / instruction_data to core
//  core_nreset   out  1   low while loading; drives core nreset
//  load_valid    in   1   loader byte valid
//  load_ready    out  1   responder accepts byte
//  load_byte     in   8   image byte; each word is sent MSB first
//  load_last     in   1   qualifies final byte of image
//  load_done     out  1   image complete, core running
//  io_out        out  32  last value stored to IO_ADDR
//  io_strobe     out  1   1-cycle pulse per IO_ADDR store
//  err_range     out  1   sticky: core access to an address that is unmapped
//  err_overflow  out  1   sticky: loader image exceeded DEPTH
//  err_collision out  1   sticky: ram_read and ram_write in same cycle
// BEHAVIOUR
//  Reset values: state=LOAD, core_nreset=0, load_ready=0 (first cycle after
//   reset release, then 1), load_done=0, io_out=0, io_strobe=0, all err*=0,
//   load_addr=0, byte_cnt=0. Storage contents are NOT cleared by reset.
//  States: LOAD -> RUN only. RUN is left only by nreset.
//  LOAD:
//   - load_ready=1. A byte is taken on a posedge with load_valid&&load_ready.
//   - Shift into word MSB first. byte_cnt counts 0..3.
//   - 4th byte: write word to mem[load_addr], load_addr++, byte_cnt=0.
//   - load_last on a byte with byte_cnt<3: pad remaining low bytes with 0 and
//     write the partial word in that same cycle.
//   - After the word containing load_last is written: next cycle state=RUN,
//     load_ready=0, load_done=1, core_nreset=1 (registered, glitch-free).
//   - load_addr==DEPTH at word write: word dropped, err_overflow=1. Loading
//     continues until load_last.
//   - In LOAD, ram_* inputs are ignored and ram_rdata=0.
//  RUN:
//   - Read is combinational: ram_rdata=mem[ram_address] when ram_read and
//     address<DEPTH, else 0. Zero latency, so the core samples at the same
//     posedge.
//   - Write is committed at posedge when ram_write and address<DEPTH. A read in
//     the following cycle returns the new value.
//   - ram_write to IO_ADDR: io_out<=ram_wdata, io_strobe=1 for exactly that
//     next cycle. ram_read of IO_ADDR returns io_out.
//   - Any other address>=DEPTH: read returns 0, write dropped, err_range=1.
//   - ram_read&&ram_write together: write performed, rdata shows pre-write
//     contents, err_collision=1.
//  Reset mid-load or mid-run:
//   - Immediate return to LOAD, core_nreset=0.
//   - A partial word in the packer is discarded. Previously written words
//     remain in memory.
//  Widths: load_addr is $clog2(DEPTH)+1 bits so overflow is detectable. The
//   address compare uses all 24 bits; no aliasing.
// STRUCTURE
//  mem_pkg:
//   - state encoding: LOAD=1'b0, RUN=1'b1
//   - default IO_ADDR
//   - WORD_W=32, ADDR_W=24
//  Sub-module byte_packer:
//   - holds byte_cnt, the shift register and last/pad handling
//   - emits word_valid + word for one cycle
//  Top: FSM, load_addr, storage array, IO register, error flags, rdata mux.
// TESTING
//  1. Load 8 bytes 12 34 56 78 9A BC DE F0 (last on F0) ->
//     mem[0]=32'h12345678, mem[1]=32'h9ABCDEF0; core_nreset rises 1 cycle
//     after the F0 handshake.
//  2. Load 6 bytes ending AA BB with last -> mem[1]=32'hAABB0000; load_done=1.
//  3. RUN: write 32'hDEADBEEF to addr 5, read addr 5 next cycle ->
//     rdata=32'hDEADBEEF same cycle as ram_read.
//  4. Write 32'h0000002A to 24'hFFFFFF -> io_out=32'h2A, io_strobe high exactly
//     1 cycle. Read addr DEPTH -> rdata=0, err_range=1.
//  5. DEPTH=4, load 5 words -> words 0..3 stored, err_overflow=1, still enters
//     RUN.
//  6. Assert nreset after 2 bytes of a word -> core_nreset=0, state LOAD; reload
//     of 4 bytes lands at mem[0].

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package memory_responder_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 24;
  localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 24'hFFFFFF;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/memory_responder_if.sv
// RAM bus plus byte-serial image loader between the core/bench and the responder.
interface memory_responder_if;
  import memory_responder_pkg::*;
  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              load_valid;
  logic              load_ready;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_done;

  modport master (
    output ram_read, ram_write, ram_address, ram_wdata,
    output load_valid, load_byte, load_last,
    input  ram_rdata, load_ready, load_done
  );
  modport slave (
    input  ram_read, ram_write, ram_address, ram_wdata,
    input  load_valid, load_byte, load_last,
    output ram_rdata, load_ready, load_done
  );
endinterface

// File: rtl/memory_responder_byte_packer.sv
// Packs loader bytes MSB-first into words; a last byte flushes a zero-padded word.
module memory_responder_byte_packer
  import memory_responder_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_last
);
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // The word is assembled combinationally so it is written on the same edge
  // that accepts its final byte.
  always_comb begin
    word = '0;
    case (byte_cnt)
      2'd0:    word = {in_byte, 24'h0};
      2'd1:    word = {shreg[7:0], in_byte, 16'h0};
      2'd2:    word = {shreg[15:0], in_byte, 8'h0};
      default: word = {shreg, in_byte};
    endcase
  end

  assign word_valid = in_valid && (byte_cnt == 2'd3 || in_last);
  assign word_last  = in_valid && in_last;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        byte_cnt <= '0;
        shreg    <= '0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= {shreg[15:0], in_byte};
      end
    end
  end
endmodule

// File: rtl/memory_responder.sv
// Unified word store: loads an image while holding the core in reset, then serves it.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int                DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] IO_ADDR = IO_ADDR_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  memory_responder_if.slave bus,
  output logic              core_nreset,
  output logic [WORD_W-1:0] io_out,
  output logic              io_strobe,
  output logic              err_range,
  output logic              err_overflow,
  output logic              err_collision
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);

  state_t            state;
  logic [LW-1:0]     load_addr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept, word_valid, word_last;
  logic [WORD_W-1:0] word;
  logic              in_range, is_io, running;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  assign accept   = bus.load_valid && bus.load_ready && (state == LOAD);
  assign running  = (state == RUN);
  assign in_range = bus.ram_address < DEPTH_A;
  assign is_io    = bus.ram_address == IO_ADDR;

  memory_responder_byte_packer u_packer (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid   (accept),
    .in_byte    (bus.load_byte),
    .in_last    (bus.load_last),
    .word_valid (word_valid),
    .word       (word),
    .word_last  (word_last)
  );

  // Single write port shared by the loader (LOAD) and core stores (RUN).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!running) begin
      mem_we    = word_valid && (load_addr < DEPTH_L);
      mem_waddr = load_addr[AW-1:0];
      mem_wdata = word;
    end else begin
      mem_we    = bus.ram_write && in_range;
      mem_waddr = bus.ram_address[AW-1:0];
      mem_wdata = bus.ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Zero-latency read; on a read/write collision this still sees pre-write data.
  always_comb begin
    bus.ram_rdata = '0;
    if (running && bus.ram_read) begin
      if (in_range)   bus.ram_rdata = mem[bus.ram_address[AW-1:0]];
      else if (is_io) bus.ram_rdata = io_out;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= LOAD;
      load_addr      <= '0;
      bus.load_ready <= 1'b0;
      bus.load_done  <= 1'b0;
      core_nreset    <= 1'b0;
      io_out         <= '0;
      io_strobe      <= 1'b0;
      err_range      <= 1'b0;
      err_overflow   <= 1'b0;
      err_collision  <= 1'b0;
    end else begin
      io_strobe <= 1'b0;
      case (state)
        LOAD: begin
          bus.load_ready <= 1'b1;
          if (word_valid) begin
            if (load_addr == DEPTH_L) err_overflow <= 1'b1;
            else                      load_addr    <= load_addr + 1'b1;
            if (word_last) begin
              state          <= RUN;
              bus.load_ready <= 1'b0;
              bus.load_done  <= 1'b1;
              core_nreset    <= 1'b1;
            end
          end
        end
        default: begin
          bus.load_ready <= 1'b0;
          if (bus.ram_write && is_io) begin
            io_out    <= bus.ram_wdata;
            io_strobe <= 1'b1;
          end
          if ((bus.ram_read || bus.ram_write) && !in_range && !is_io)
            err_range <= 1'b1;
          if (bus.ram_read && bus.ram_write)
            err_collision <= 1'b1;
        end
      endcase
    end
  end
endmodule
